usr_seq_ctrl: RTL
=================

USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  transfer request, sampled in IDLE only.
REQ-005 SHALL have port dir  input  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
REQ-006 SHALL have port p_in  input  WIDTH  parallel word to load.
REQ-007 SHALL have port ser_in  input  1  serial bit entering the vacated end on each shift.
REQ-008 SHALL have port ser_out  output  1  serial bit leaving the register.
REQ-009 SHALL have port p_out  output  WIDTH  current register contents.
REQ-010 SHALL have port sel  output  2  current mode: 00 hold, 01 shift left, 10 shift right, 11 load.
REQ-011 SHALL have port busy  output  1  high in LOAD, SHIFT and DONE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: sel=00, register holds; start=1 at an edge -> LOAD, with dir and p_in captured into internal latches on that edge.
REQ-015 LOAD: sel=11; next edge -> register = captured p_in, bit counter = 0, go to SHIFT.
REQ-016 SHIFT: sel=01 when captured dir=0, else 10.
REQ-017 In SHIFT, each edge shifts by one and increments the counter; the edge on which counter reaches WIDTH -> DONE.
REQ-018 Shift left SHALL do reg <= {reg[WIDTH-2:0], ser_in}; shift right SHALL do reg <= {ser_in, reg[WIDTH-1:1]}.
REQ-019 ser_out SHALL be reg[WIDTH-1] when captured dir=0, else reg[0]; combinational from the register.
REQ-020 DONE: sel=00, done=1 for exactly one cycle; next edge -> IDLE.
REQ-021 Latency: start accepted at edge N -> first serial bit valid in cycle after edge N+1 -> done high in cycle after edge N+1+WIDTH.
REQ-022 start while busy=1 SHALL be ignored and not queued; start in IDLE coincident with the DONE->IDLE edge is not possible (DONE is not IDLE).
REQ-023 dir and p_in changes while busy=1 SHALL have no effect on the transfer in progress.
REQ-024 After DONE, p_out SHALL hold the WIDTH ser_in bits shifted in, until the next LOAD.

Reset
REQ-025 rst=1 at any edge, including mid-LOAD or mid-SHIFT, SHALL force IDLE, register=0, counter=0, and captured dir=0.
REQ-026 Resulting outputs: ser_out=0, p_out=0, sel=00, busy=0, done=0.
REQ-027 rst SHALL take priority over start and abort.

Configuration
REQ-028 Macro USR_SEQ_ABORT_EN defined: input port abort (1 bit) SHALL exist.
REQ-029 abort=1 in LOAD or SHIFT SHALL force IDLE at the next edge with register held and no done pulse; it SHALL have no effect in IDLE or DONE.
REQ-030 Macro undefined: no abort port; behaviour identical to abort tied 0.

Structure
REQ-031 Package usr_pkg SHALL hold the sel encodings (SEL_HOLD, SEL_LEFT, SEL_RIGHT, SEL_LOAD) and the FSM state enum.
REQ-032 The register datapath SHALL be sub-module usr_core (clk, rst, sel, ser_in, p_in, q), driven by the FSM in usr_seq_ctrl.

Verification
REQ-033 Reset then idle: rst=1 for 2 cycles -> p_out=0000, sel=00, busy=0, done=0.
REQ-034 Left serialize: WIDTH=4, p_in=1011, dir=0, ser_in=0, start pulse:
- ser_out sequence 1,0,1,1.
- done one cycle after the 4th shift.
- p_out=0000.
REQ-035 Right deserialize: p_in=0000, dir=1, ser_in sequence 1,1,0,1 -> p_out=1011, ser_out sequence 0,0,0,0.
REQ-036 Busy lockout: start and a changed p_in=1111 asserted during SHIFT -> no restart, original transfer completes, exactly one done pulse.
REQ-037 Reset mid-shift: rst=1 after the 2nd shift -> next cycle IDLE, p_out=0000, no done pulse.
REQ-038 With USR_SEQ_ABORT_EN: abort=1 during SHIFT after 2 shifts of p_in=1100 (dir=0, ser_in=0):
- IDLE next cycle, p_out=0000, done never asserted.
- New start accepted 1 cycle later.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg -- shared definitions for the universal shift-register sequencer.
//   SEL_* : register mode encodings driven onto the usr_core sel bus
//           (00 hold, 01 shift left, 10 shift right, 11 parallel load).
//   state_t : sequencer FSM states.
//   shift_sel() : maps a captured direction bit to its shift mode.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // dir = 0 shifts left (MSB leaves first), dir = 1 shifts right.
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_RIGHT : SEL_LEFT;
  endfunction

endpackage

// File: rtl/usr_core.sv
// usr_core -- universal shift register datapath.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears q
//   sel    : mode (usr_pkg SEL_*): hold / shift left / shift right / load
//   ser_in : bit entering the vacated end on a shift
//   p_in   : parallel word taken on load
//   q      : register contents
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LEFT:  q <= {q[WIDTH-2:0], ser_in};
        SEL_RIGHT: q <= {ser_in, q[WIDTH-1:1]};
        SEL_LOAD:  q <= p_in;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl -- sequencer that loads a word into usr_core and shifts it
// out/in serially over WIDTH cycles, then pulses done.
// Optional feature: define USR_SEQ_ABORT_EN to add the abort input, which
// returns LOAD/SHIFT to IDLE with the register held and no done pulse.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : transfer request, only honoured in IDLE
//   dir      : 0 = shift left (MSB first), 1 = shift right (LSB first)
//   p_in     : parallel word, captured together with dir on start
//   ser_in   : serial bit shifted into the register
//   abort    : (USR_SEQ_ABORT_EN only) cancel transfer in LOAD/SHIFT
//   ser_out  : bit leaving the register for the captured direction
//   p_out    : register contents
//   sel      : current register mode (usr_pkg SEL_*)
//   busy     : high in LOAD, SHIFT and DONE
//   done     : one-cycle completion pulse
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] p_in,
  input  logic             ser_in,
`ifdef USR_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             ser_out,
  output logic [WIDTH-1:0] p_out,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic             cap_dir;
  logic [WIDTH-1:0] cap_data;
  logic [CW-1:0]    cnt;
  logic             abort_req;
  logic [WIDTH-1:0] q;

`ifdef USR_SEQ_ABORT_EN
  // Abort only matters while a transfer is being loaded or shifted.
  assign abort_req = abort && (state == ST_LOAD || state == ST_SHIFT);
`else
  assign abort_req = 1'b0;
`endif

  // An abort forces hold so the register keeps its value on the abort edge.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    sel = SEL_HOLD;
    if (!abort_req) begin
      case (state)
        ST_LOAD:  sel = SEL_LOAD;
        ST_SHIFT: sel = shift_sel(cap_dir);
        default:  sel = SEL_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cap_dir  <= 1'b0;
      cap_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            cap_dir  <= dir;
            cap_data <= p_in;
          end
        end
        ST_LOAD: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            // The edge that brings the count to WIDTH ends the transfer.
            if (cnt == LAST_CNT) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .ser_in (ser_in),
    .p_in   (cap_data),
    .q      (q)
  );

  assign p_out   = q;
  assign ser_out = cap_dir ? q[0] : q[WIDTH-1];
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule
